// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input and flags a stuck line.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample filter on the synchronized level.
module pwm_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic        pwm_in,
    input  logic [15:0] timeout,
    output logic [15:0] period_meas,
    output logic [15:0] high_meas,
    output logic        meas_valid,
    output logic        overflow,
    output logic        stuck_high,
    output logic        stuck_low
);

    typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, STUCK} state_t;

    state_t      state;
    state_t      state_next;

    logic        sync_a;
    logic        sync_b;
    logic        level;
    logic        level_hist;
    logic        rise;
    logic        fall;
    logic        any_edge;
    logic        timed_out;

    logic [15:0] cnt;
    logic [15:0] high_cap;

    logic        cnt_load;
    logic        cap_high;
    logic        take_meas;
    logic        set_stuck;
    logic        clr_stuck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= pwm_in;
            sync_b <= sync_a;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic samp_1;
    logic samp_2;
    logic filt_q;

    // Level only moves once three consecutive synchronized samples agree.
    assign level = ((sync_b == samp_1) && (samp_1 == samp_2)) ? sync_b : filt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_1 <= 1'b0;
            samp_2 <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            samp_1 <= sync_b;
            samp_2 <= samp_1;
            filt_q <= level;
        end
    end
`else
    assign level = sync_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_hist <= 1'b0;
        end else begin
            level_hist <= level;
        end
    end

    assign rise      = level & ~level_hist;
    assign fall      = ~level & level_hist;
    assign any_edge  = level ^ level_hist;
    // An edge in the same cycle always beats the timeout.
    assign timed_out = (timeout != 16'd0) && (cnt >= timeout) && !any_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!cap_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = ARM;
                ARM: begin
                    if (rise) begin
                        state_next = HIGH;
                    end else if (timed_out) begin
                        state_next = STUCK;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_next = LOW;
                    end else if (timed_out) begin
                        state_next = STUCK;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_next = HIGH;
                    end else if (timed_out) begin
                        state_next = STUCK;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state_next = HIGH;
                    end else if (fall) begin
                        state_next = ARM;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_load  = 1'b0;
        cap_high  = 1'b0;
        take_meas = 1'b0;
        set_stuck = 1'b0;
        clr_stuck = !cap_en;
        if (cap_en) begin
            case (state)
                IDLE: cnt_load = 1'b1;
                ARM: begin
                    cnt_load  = rise;
                    set_stuck = timed_out;
                end
                HIGH: begin
                    cap_high  = fall;
                    set_stuck = timed_out;
                end
                LOW: begin
                    cnt_load  = rise;
                    take_meas = rise;
                    set_stuck = timed_out;
                end
                STUCK: begin
                    cnt_load  = any_edge;
                    clr_stuck = any_edge;
                end
                default: cnt_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 16'd0;
            high_cap <= 16'd0;
        end else begin
            if (cnt_load) begin
                cnt <= 16'd1;
            end else if ((state != IDLE) && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
            if (cap_high) begin
                high_cap <= cnt;
            end
        end
    end

    // Results and overflow only change together with the strobe, so they survive cap_en drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_meas <= 16'd0;
            high_meas   <= 16'd0;
            meas_valid  <= 1'b0;
            overflow    <= 1'b0;
            stuck_high  <= 1'b0;
            stuck_low   <= 1'b0;
        end else begin
            meas_valid <= take_meas;
            if (take_meas) begin
                period_meas <= cnt;
                high_meas   <= high_cap;
                overflow    <= (cnt == 16'hFFFF) || (high_cap == 16'hFFFF);
            end
            if (clr_stuck) begin
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end else if (set_stuck) begin
                stuck_high <= level;
                stuck_low  <= ~level;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives known PWM pulse trains into pwm_capture and compares every strobe
// against the period/high values the bench itself generated.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en;
    logic        pwm_in;
    logic [15:0] timeout;
    logic [15:0] period_meas;
    logic [15:0] high_meas;
    logic        meas_valid;
    logic        overflow;
    logic        stuck_high;
    logic        stuck_low;

    pwm_capture dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .pwm_in     (pwm_in),
        .timeout    (timeout),
        .period_meas(period_meas),
        .high_meas  (high_meas),
        .meas_valid (meas_valid),
        .overflow   (overflow),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int DROP_DELAY = 4;
`else
    localparam int DROP_DELAY = 2;
`endif

    typedef struct {
        int period;
        int high;
        bit ovf;
        int cyc;
    } meas_t;

    meas_t obs_q[$];
    meas_t exp_q[$];
    meas_t mon_m;
    int    cycle = 0;
    int    checks = 0;
    int    errors = 0;
    bit    stuck_seen = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            mon_m.period = int'(period_meas);
            mon_m.high   = int'(high_meas);
            mon_m.ovf    = overflow;
            mon_m.cyc    = cycle;
            obs_q.push_back(mon_m);
        end
        if (!rst && (stuck_high || stuck_low)) stuck_seen = 1'b1;
    end

    // Reference: a pulse of P clocks with H high reads back as P/H, clipped at 16 bits.
    function automatic void expect_meas(int p, int h);
        meas_t m;
        m.period = (p > 65535) ? 65535 : p;
        m.high   = (h > 65535) ? 65535 : h;
        m.ovf    = (p >= 65535) || (h >= 65535);
        m.cyc    = 0;
        exp_q.push_back(m);
    endfunction

    task automatic drive_pulse(int p, int h);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic final_rise();
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; cap_en = 1'b0; pwm_in = 1'b0; timeout = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        obs_q.delete(); exp_q.delete(); stuck_seen = 1'b0;
    endtask

    task automatic start_capture(logic [15:0] t);
        timeout = t;
        cap_en  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; cap_en = 1'b0; pwm_in = 1'b0; timeout = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({period_meas, high_meas, meas_valid, overflow, stuck_high, stuck_low} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got p=%0d h=%0d v=%0b o=%0b sh=%0b sl=%0b want all 0",
                     period_meas, high_meas, meas_valid, overflow, stuck_high, stuck_low);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        apply_reset();
        start_capture(16'd0);
        repeat (5) begin
            drive_pulse(100, 25);
            expect_meas(100, 25);
        end
        final_rise();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high ||
                obs_q[i].ovf !== exp_q[i].ovf) begin
                errors++;
                $display("[TB] FAIL basic_meas[%0d] got p=%0d h=%0d o=%0b want p=%0d h=%0d o=%0b", i,
                         obs_q[i].period, obs_q[i].high, obs_q[i].ovf,
                         exp_q[i].period, exp_q[i].high, exp_q[i].ovf);
            end
            if (i > 0) begin
                checks++;
                if (obs_q[i].cyc - obs_q[i-1].cyc !== 100) begin
                    errors++;
                    $display("[TB] FAIL basic_spacing[%0d] got %0d want 100", i,
                             obs_q[i].cyc - obs_q[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_random();
        int p;
        int h;
        apply_reset();
        start_capture(16'($urandom_range(1000, 301)));
        repeat (15) begin
            p = $urandom_range(300, 6);
            h = $urandom_range(p - 3, 3);
            drive_pulse(p, h);
            expect_meas(p, h);
        end
        final_rise();
        checks++;
        if (obs_q.size() !== exp_q.size() || stuck_seen) begin
            errors++;
            $display("[TB] FAIL random_count got %0d stuck=%0b want %0d stuck=0",
                     obs_q.size(), stuck_seen, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high ||
                obs_q[i].ovf !== exp_q[i].ovf) begin
                errors++;
                $display("[TB] FAIL random_meas[%0d] got p=%0d h=%0d o=%0b want p=%0d h=%0d o=%0b", i,
                         obs_q[i].period, obs_q[i].high, obs_q[i].ovf,
                         exp_q[i].period, exp_q[i].high, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_timeout_boundary();
        // timeout equal to the period: the rise lands on the timeout cycle and must win.
        apply_reset();
        start_capture(16'd50);
        repeat (4) begin
            drive_pulse(50, 20);
            expect_meas(50, 20);
        end
        final_rise();
        checks++;
        if (obs_q.size() !== exp_q.size() || stuck_seen) begin
            errors++;
            $display("[TB] FAIL tmo_equal got %0d stuck=%0b want %0d stuck=0",
                     obs_q.size(), stuck_seen, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high) begin
                errors++;
                $display("[TB] FAIL tmo_equal_meas[%0d] got p=%0d h=%0d want p=%0d h=%0d", i,
                         obs_q[i].period, obs_q[i].high, exp_q[i].period, exp_q[i].high);
            end
        end
        // One clock shorter: every low phase times out first, so nothing is ever measured.
        apply_reset();
        start_capture(16'd49);
        repeat (4) drive_pulse(50, 20);
        final_rise();
        checks++;
        if (obs_q.size() !== 0 || !stuck_seen) begin
            errors++;
            $display("[TB] FAIL tmo_short got %0d stuck=%0b want 0 stuck=1", obs_q.size(), stuck_seen);
        end
    endtask

    task automatic test_stuck();
        int waited;
        apply_reset();
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        timeout = 16'd50;
        cap_en  = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (stuck_high !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_early got %0b want 0", stuck_high);
        end
        waited = 0;
        while (stuck_high !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (stuck_high !== 1'b1 || stuck_low !== 1'b0 || obs_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL stuck_high_flag got sh=%0b sl=%0b meas=%0d want sh=1 sl=0 meas=0",
                     stuck_high, stuck_low, obs_q.size());
        end
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_clear_fall got sh=%0b sl=%0b want 0 0", stuck_high, stuck_low);
        end
        repeat (3) begin
            drive_pulse(40, 10);
            expect_meas(40, 10);
        end
        final_rise();
        pwm_in = 1'b0;
        waited = 0;
        while (stuck_low !== 1'b1 && waited < 80) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (stuck_low !== 1'b1 || stuck_high !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_low_flag got sh=%0b sl=%0b want sh=0 sl=1", stuck_high, stuck_low);
        end
        // Leaving STUCK on a rise restarts the measurement without a strobe.
        repeat (2) begin
            drive_pulse(40, 10);
            expect_meas(40, 10);
        end
        final_rise();
        checks++;
        if (stuck_low !== 1'b0 || stuck_high !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_clear_rise got sh=%0b sl=%0b want 0 0", stuck_high, stuck_low);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL stuck_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high) begin
                errors++;
                $display("[TB] FAIL stuck_meas[%0d] got p=%0d h=%0d want p=%0d h=%0d", i,
                         obs_q[i].period, obs_q[i].high, exp_q[i].period, exp_q[i].high);
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        start_capture(16'd0);
        drive_pulse(65540, 100);
        expect_meas(65540, 100);
        drive_pulse(50, 20);
        expect_meas(50, 20);
        final_rise();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL ovf_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high ||
                obs_q[i].ovf !== exp_q[i].ovf) begin
                errors++;
                $display("[TB] FAIL ovf_meas[%0d] got p=%0d h=%0d o=%0b want p=%0d h=%0d o=%0b", i,
                         obs_q[i].period, obs_q[i].high, obs_q[i].ovf,
                         exp_q[i].period, exp_q[i].high, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_reset_mid_high();
        apply_reset();
        start_capture(16'd0);
        drive_pulse(80, 30);
        drive_pulse(80, 30);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (period_meas !== 16'd80) begin
            errors++;
            $display("[TB] FAIL premid_period got %0d want 80", period_meas);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({period_meas, high_meas, meas_valid, overflow, stuck_high, stuck_low} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got p=%0d h=%0d v=%0b o=%0b want all 0",
                     period_meas, high_meas, meas_valid, overflow);
        end
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_q.delete(); exp_q.delete();
        repeat (4) @(negedge clk);
        drive_pulse(60, 15);
        expect_meas(60, 15);
        drive_pulse(45, 20);
        expect_meas(45, 20);
        final_rise();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL midreset_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high) begin
                errors++;
                $display("[TB] FAIL midreset_meas[%0d] got p=%0d h=%0d want p=%0d h=%0d", i,
                         obs_q[i].period, obs_q[i].high, exp_q[i].period, exp_q[i].high);
            end
        end
    endtask

    task automatic test_cap_en_drop();
        apply_reset();
        start_capture(16'd0);
        drive_pulse(70, 30);
        drive_pulse(90, 40);
        pwm_in = 1'b1;
        repeat (DROP_DELAY) @(negedge clk);
        cap_en = 1'b0;
        repeat (30 - DROP_DELAY) @(negedge clk);
        pwm_in = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (period_meas !== 16'd70 || high_meas !== 16'd30 || overflow !== 1'b0 || obs_q.size() !== 1) begin
            errors++;
            $display("[TB] FAIL drop_retained got p=%0d h=%0d o=%0b n=%0d want p=70 h=30 o=0 n=1",
                     period_meas, high_meas, overflow, obs_q.size());
        end
        obs_q.delete();
        cap_en = 1'b1;
        repeat (4) @(negedge clk);
        repeat (2) begin
            drive_pulse(55, 12);
            expect_meas(55, 12);
        end
        final_rise();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL drop_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high) begin
                errors++;
                $display("[TB] FAIL drop_meas[%0d] got p=%0d h=%0d want p=%0d h=%0d", i,
                         obs_q[i].period, obs_q[i].high, exp_q[i].period, exp_q[i].high);
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        start_capture(16'd0);
        drive_pulse(60, 20);
        drive_pulse(40, 20);
        drive_pulse(20, 1);
        drive_pulse(60, 20);
        final_rise();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        expect_meas(60, 20);
        expect_meas(60, 20);
        expect_meas(60, 20);
`else
        expect_meas(60, 20);
        expect_meas(40, 20);
        expect_meas(20, 1);
        expect_meas(60, 20);
`endif
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL glitch_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high) begin
                errors++;
                $display("[TB] FAIL glitch_meas[%0d] got p=%0d h=%0d want p=%0d h=%0d", i,
                         obs_q[i].period, obs_q[i].high, exp_q[i].period, exp_q[i].high);
            end
        end
    endtask

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog expired got running want finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_timeout_boundary();
        test_stuck();
        test_reset_mid_high();
        test_cap_en_drop();
        test_glitch();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
